// File: rtl/jtag_shift_master_if.sv
// Command/response bundle between a JTAG host controller and jtag_shift_master.
// Latency: none, wires only.
// Backpressure: cmd_valid/cmd_ready and rsp_valid/rsp_ready handshakes.
interface jtag_shift_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [5:0]  cmd_len;
  logic [31:0] cmd_data;
  logic        cmd_tms_last;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_len, cmd_data, cmd_tms_last, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_len, cmd_data, cmd_tms_last, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/jtag_shift_master.sv
// JTAG driver: one TMS walk or TDI shift (1..32 bits) per command, TDO captured LSB-first.
// Latency: 2*CLKDIV*len cycles from accept to rsp_valid (1 cycle for len=0 or reserved op).
// Backpressure: cmd_ready is low until the response is taken; rsp held while rsp_ready=0.
// Optional JTAG_TDO_SYNC_EN: adds a two-flop tdo synchroniser (needs CLKDIV >= 3).
module jtag_shift_master #(
  parameter int CLKDIV = 4
) (
  input  logic                clk,
  input  logic                reset,
  jtag_shift_master_if.slave  bus,
  output logic                busy,
  output logic                tck,
  output logic                tms,
  output logic                tdi,
  input  logic                tdo
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, RESP} state_t;

  localparam logic [7:0] PHASE_LAST = 8'(CLKDIV - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [4:0]  idx_q, idx_d;
  logic [5:0]  len_q, len_d;
  logic        shift_q, shift_d;
  logic        tms_last_q, tms_last_d;
  logic [31:0] data_q, data_d;
  logic [31:0] cap_q, cap_d;
  logic        err_q, err_d;
  logic        pend_q, pend_d;
  logic        tms_q, tms_d;
  logic        tdi_q, tdi_d;

  logic        tdo_cap;
  logic        accept;
  logic        degen;
  logic        phase_end;
  logic        last_bit;
  logic [5:0]  eff_len;
  logic [4:0]  idx_nxt;

  if (CLKDIV < 2 || CLKDIV > 255) begin : g_clkdiv_range
    $error("jtag_shift_master: CLKDIV must be in 2..255");
  end

`ifdef JTAG_TDO_SYNC_EN
  logic tdo_s1_q, tdo_s2_q;

  if (CLKDIV < 3) begin : g_clkdiv_sync
    $error("jtag_shift_master: JTAG_TDO_SYNC_EN needs CLKDIV >= 3");
  end

  // Two-flop synchroniser; capture edge unchanged, so data is 2 cycles old.
  always_ff @(posedge clk) begin
    if (reset) begin
      tdo_s1_q <= 1'b0;
      tdo_s2_q <= 1'b0;
    end else begin
      tdo_s1_q <= tdo;
      tdo_s2_q <= tdo_s1_q;
    end
  end

  assign tdo_cap = tdo_s2_q;
`else
  assign tdo_cap = tdo;
`endif

  assign accept    = bus.cmd_valid && bus.cmd_ready;
  assign eff_len   = (bus.cmd_len > 6'd32) ? 6'd32 : bus.cmd_len;
  assign degen     = bus.cmd_op[1] || (eff_len == 6'd0);
  assign phase_end = (cnt_q == PHASE_LAST);
  assign last_bit  = ({1'b0, idx_q} == (len_q - 6'd1));
  assign idx_nxt   = idx_q + 5'd1;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; degenerate commands wait one cycle in IDLE (pend) before RESP.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (pend_q)                 state_d = RESP;
        else if (accept && !degen)  state_d = LOW;
      end
      LOW:  if (phase_end) state_d = HIGH;
      HIGH: if (phase_end) state_d = last_bit ? RESP : LOW;
      RESP: if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from registered state; pins come straight from flops.
  always_comb begin
    tck           = (state_q == HIGH);
    busy          = (state_q == LOW) || (state_q == HIGH);
    bus.cmd_ready = (state_q == IDLE) && !pend_q;
    bus.rsp_valid = (state_q == RESP);
    bus.rsp_data  = cap_q;
    bus.rsp_err   = err_q;
    tms           = tms_q;
    tdi           = tdi_q;
  end

  // Datapath next values: latch command, step bits on tck fall, capture on tck rise.
  always_comb begin
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    len_d      = len_q;
    shift_d    = shift_q;
    tms_last_d = tms_last_q;
    data_d     = data_q;
    cap_d      = cap_q;
    err_d      = err_q;
    pend_d     = 1'b0;
    tms_d      = tms_q;
    tdi_d      = tdi_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          data_d     = bus.cmd_data;
          len_d      = eff_len;
          shift_d    = (bus.cmd_op == 2'd1);
          tms_last_d = bus.cmd_tms_last;
          idx_d      = 5'd0;
          cnt_d      = 8'd0;
          cap_d      = 32'd0;
          err_d      = bus.cmd_op[1];
          pend_d     = degen;
          // Reserved or empty commands leave the TAP pins untouched.
          if (!degen) begin
            if (bus.cmd_op == 2'd1) begin
              tdi_d = bus.cmd_data[0];
              tms_d = (eff_len == 6'd1) ? bus.cmd_tms_last : 1'b0;
            end else begin
              tdi_d = 1'b0;
              tms_d = bus.cmd_data[0];
            end
          end
        end
      end
      LOW: begin
        cnt_d = cnt_q + 8'd1;
        if (phase_end) begin
          cnt_d        = 8'd0;
          cap_d[idx_q] = tdo_cap;
        end
      end
      HIGH: begin
        cnt_d = cnt_q + 8'd1;
        if (phase_end) begin
          cnt_d = 8'd0;
          if (!last_bit) begin
            idx_d = idx_nxt;
            if (shift_q) begin
              tdi_d = data_q[idx_nxt];
              tms_d = ({1'b0, idx_nxt} == (len_q - 6'd1)) ? tms_last_q : 1'b0;
            end else begin
              tdi_d = 1'b0;
              tms_d = data_q[idx_nxt];
            end
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; tms resets high so the TAP idles in Test-Logic-Reset walks.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= 8'd0;
      idx_q      <= 5'd0;
      len_q      <= 6'd0;
      shift_q    <= 1'b0;
      tms_last_q <= 1'b0;
      data_q     <= 32'd0;
      cap_q      <= 32'd0;
      err_q      <= 1'b0;
      pend_q     <= 1'b0;
      tms_q      <= 1'b1;
      tdi_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      len_q      <= len_d;
      shift_q    <= shift_d;
      tms_last_q <= tms_last_d;
      data_q     <= data_d;
      cap_q      <= cap_d;
      err_q      <= err_d;
      pend_q     <= pend_d;
      tms_q      <= tms_d;
      tdi_q      <= tdi_d;
    end
  end

endmodule

// File: tb/tb_jtag_shift_master.sv
// Directed bench for jtag_shift_master: vector table plus reset/backpressure sequences.
// Latency: n/a.
// Backpressure: exercised by holding rsp_ready low in one hand-written sequence.
module tb_jtag_shift_master;

`ifdef JTAG_TDO_SYNC_EN
  localparam int C = 3;
`else
  localparam int C = 2;
`endif

  logic clk = 1'b0;
  logic reset;
  logic busy, tck, tms, tdi, tdo;
  logic inv_tdo = 1'b0;

  always #5 clk = ~clk;

  // TDO loops back from TDI, optionally inverted so unused upper bits would show as ones.
  assign tdo = inv_tdo ? ~tdi : tdi;

  jtag_shift_master_if bus ();

  jtag_shift_master #(.CLKDIV(C)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .busy  (busy),
    .tck   (tck),
    .tms   (tms),
    .tdi   (tdi),
    .tdo   (tdo)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [5:0]  len;
    logic [31:0] data;
    logic        tl;
    logic        inv;
    int          pulses;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  task automatic run_cmd(input vec_t v, output int pulses, output int lat,
                         output logic [31:0] rdata, output logic rerr,
                         output logic [31:0] tdi_seen, output logic [31:0] tms_seen,
                         output int bad_width, output int toggles, output logic ready_after);
    int   guard;
    int   hi;
    logic prev_tck;
    logic tms0, tdi0;
    guard = 0;
    while (bus.cmd_ready !== 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    inv_tdo          = v.inv;
    bus.cmd_valid    = 1'b1;
    bus.cmd_op       = v.op;
    bus.cmd_len      = v.len;
    bus.cmd_data     = v.data;
    bus.cmd_tms_last = v.tl;
    tms0 = tms;
    tdi0 = tdi;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    pulses = 0; lat = -1; hi = 0; prev_tck = 1'b0; bad_width = 0; toggles = 0;
    rdata = 32'hx; rerr = 1'bx; tdi_seen = 32'd0; tms_seen = 32'd0;
    for (int cyc = 0; cyc < 3000 && lat < 0; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (tck && !prev_tck) begin
        if (pulses < 32) begin
          tdi_seen[pulses] = tdi;
          tms_seen[pulses] = tms;
        end
        pulses++;
        hi = 0;
      end
      if (tck) hi++;
      if (!tck && prev_tck && hi != C) bad_width++;
      if (tms !== tms0 || tdi !== tdi0) toggles++;
      prev_tck = tck;
      if (bus.rsp_valid === 1'b1) begin
        lat   = cyc;
        rdata = bus.rsp_data;
        rerr  = bus.rsp_err;
      end
    end
    @(negedge clk);
    ready_after = bus.cmd_ready;
  endtask

  vec_t vecs[11];

  initial begin
    int          pulses, lat, bad_width, toggles, exp_lat, seen;
    logic [31:0] rdata, tdi_seen, tms_seen, mask, exp_tdi, exp_tms;
    logic        rerr, ready_after;

    //            op     len    data          tl    inv   pulses rdata         err
    vecs[0]  = '{2'd0, 6'd5,  32'h0000001F, 1'b0, 1'b1, 5,  32'h0000001F, 1'b0};
    vecs[1]  = '{2'd1, 6'd8,  32'h000000A5, 1'b1, 1'b0, 8,  32'h000000A5, 1'b0};
    vecs[2]  = '{2'd1, 6'd0,  32'h000000FF, 1'b0, 1'b1, 0,  32'h00000000, 1'b0};
    vecs[3]  = '{2'd1, 6'd40, 32'hDEADBEEF, 1'b0, 1'b0, 32, 32'hDEADBEEF, 1'b0};
    vecs[4]  = '{2'd3, 6'd8,  32'h000000FF, 1'b1, 1'b1, 0,  32'h00000000, 1'b1};
    vecs[5]  = '{2'd2, 6'd4,  32'h0000000F, 1'b0, 1'b1, 0,  32'h00000000, 1'b1};
    vecs[6]  = '{2'd1, 6'd1,  32'h00000000, 1'b1, 1'b1, 1,  32'h00000001, 1'b0};
    vecs[7]  = '{2'd1, 6'd32, 32'h12345678, 1'b0, 1'b1, 32, 32'hEDCBA987, 1'b0};
    vecs[8]  = '{2'd1, 6'd12, 32'h00000ABC, 1'b0, 1'b1, 12, 32'h00000543, 1'b0};
    vecs[9]  = '{2'd0, 6'd3,  32'h00000005, 1'b0, 1'b0, 3,  32'h00000000, 1'b0};
    vecs[10] = '{2'd3, 6'd0,  32'h00000003, 1'b0, 1'b0, 0,  32'h00000000, 1'b1};

    reset = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_op = 2'd0; bus.cmd_len = 6'd0;
    bus.cmd_data = 32'd0; bus.cmd_tms_last = 1'b0; bus.rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset tck",       32'(tck), 32'd0);
    check("reset tms",       32'(tms), 32'd1);
    check("reset tdi",       32'(tdi), 32'd0);
    check("reset cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("reset busy",      32'(busy), 32'd0);
    check("reset rsp_data",  bus.rsp_data, 32'd0);
    check("reset rsp_err",   32'(bus.rsp_err), 32'd0);

    foreach (vecs[k]) begin
      run_cmd(vecs[k], pulses, lat, rdata, rerr, tdi_seen, tms_seen, bad_width, toggles, ready_after);
      exp_lat = (vecs[k].pulses == 0) ? 1 : 2 * C * vecs[k].pulses;
      mask    = (vecs[k].pulses >= 32) ? 32'hFFFFFFFF : ((32'd1 << vecs[k].pulses) - 32'd1);
      exp_tdi = (vecs[k].op == 2'd1) ? (vecs[k].data & mask) : 32'd0;
      if (vecs[k].op == 2'd0)       exp_tms = vecs[k].data & mask;
      else if (vecs[k].pulses > 0)  exp_tms = 32'(vecs[k].tl) << (vecs[k].pulses - 1);
      else                          exp_tms = 32'd0;
      $display("vector %0d: op=%0d len=%0d data=0x%0h", k, vecs[k].op, vecs[k].len, vecs[k].data);
      check("tck pulses",  32'(pulses), 32'(vecs[k].pulses));
      check("rsp latency", 32'(lat), 32'(exp_lat));
      check("rsp_data",    rdata, vecs[k].rdata);
      check("rsp_err",     32'(rerr), 32'(vecs[k].err));
      check("tdi per bit", tdi_seen, exp_tdi);
      check("tms per bit", tms_seen, exp_tms);
      check("tck high width errors", 32'(bad_width), 32'd0);
      check("cmd_ready after rsp", 32'(ready_after), 32'd1);
      if (vecs[k].pulses == 0) check("pin toggles", 32'(toggles), 32'd0);
    end

    // Backpressure: response must hold while rsp_ready is low.
    bus.rsp_ready = 1'b0;
    inv_tdo = 1'b0;
    bus.cmd_valid = 1'b1; bus.cmd_op = 2'd1; bus.cmd_len = 6'd4;
    bus.cmd_data = 32'h9; bus.cmd_tms_last = 1'b0;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 200 && seen == 0; i++) begin
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) seen = 1;
    end
    check("bp rsp seen", 32'(seen), 32'd1);
    check("bp rsp_data", bus.rsp_data, 32'h9);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp cmd_ready low", 32'(bus.cmd_ready), 32'd0);
      check("bp rsp_valid held", 32'(bus.rsp_valid), 32'd1);
      check("bp rsp_data stable", bus.rsp_data, 32'h9);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    check("bp rsp_valid dropped", 32'(bus.rsp_valid), 32'd0);
    check("bp cmd_ready rises", 32'(bus.cmd_ready), 32'd1);

    // Reset during bit 3 (high phase) of a 16-bit shift.
    bus.cmd_valid = 1'b1; bus.cmd_op = 2'd1; bus.cmd_len = 6'd16;
    bus.cmd_data = 32'hFFFF; bus.cmd_tms_last = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    repeat (7 * C + 1) @(negedge clk);
    check("mid busy", 32'(busy), 32'd1);
    check("mid tck",  32'(tck),  32'd1);
    check("mid tdi",  32'(tdi),  32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("abort tck",       32'(tck), 32'd0);
    check("abort tms",       32'(tms), 32'd1);
    check("abort tdi",       32'(tdi), 32'd0);
    check("abort busy",      32'(busy), 32'd0);
    check("abort rsp_valid", 32'(bus.rsp_valid), 32'd0);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 50 * C; i++) begin
      @(negedge clk);
      if (bus.rsp_valid !== 1'b0 || tck !== 1'b0) seen++;
    end
    check("abort no rsp or tck", 32'(seen), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
